mem_responder: RTL and testbench

//  Memory-side responder to the datapath's MAR/MDR memory interface. Serves Read/Write requests with a

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/mem_resp_array.sv | 45 ++++
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared encodings for the memory responder
// Contents: FSM state encoding, latched operation encoding, wait counter width.
package mem_resp_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - storage array with one write port and a registered read port
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (read register only)
//   we, re       write / read enable, asserted by the FSM in the access cycle
//   clr          clears the read register instead of loading it
//   idx          word index
//   wdata        write data
//   rdata        registered read data
import mem_resp_pkg::*;

module mem_resp_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder for the MAR/MDR interface
// Ports:
//   Clock, Reset_n  clock, asynchronous active-low reset
//   Read, Write     level requests, held until Ready is seen
//   Addr, Wdata     word address and write data, latched at acceptance
//   Rdata           registered read data
//   Ready           one-cycle completion pulse
//   Busy            high whenever the FSM is not idle
//   Err             out-of-range address flag, coincident with Ready
// Build option: MEM_RESPONDER_ERR_EN enables out-of-range detection;
//   without it upper address bits alias and Err stays 0.
import mem_resp_pkg::*;

module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Wdata,
  output logic [DATA_W-1:0] Rdata,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  state_t              state;
  logic [WAIT_W-1:0]   count;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ready_q;
  logic                busy_q;
  logic                err_q;

  logic access;
  logic oor;
  logic arr_we;
  logic arr_re;
  logic arr_clr;

  // The access happens on the edge that leaves WAIT with an exhausted count.
  assign access = (state == WAIT) && (count == '0);

`ifdef MEM_RESPONDER_ERR_EN
  assign oor = ({1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH));
`else
  // Upper address bits are intentionally dropped so addresses alias.
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W];
`endif

  assign arr_we  = access && (op_q == OP_WR) && !oor;
  assign arr_re  = access && (op_q == OP_RD) && !oor;
  assign arr_clr = access && oor;

  mem_resp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (Clock),
    .rst_n (Reset_n),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .idx   (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (Rdata)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (Read || Write) begin
            state   <= WAIT;
            busy_q  <= 1'b1;
            count   <= WAIT_INIT;
            // Write wins when both requests are raised together.
            op_q    <= Write ? OP_WR : OP_RD;
            addr_q  <= Addr;
            wdata_q <= Wdata;
          end
        end
        WAIT: begin
          if (count == '0) begin
            state   <= DONE;
            ready_q <= 1'b1;
            err_q   <= oor;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          // A still-held request parks in RELEASE so it is not re-served.
          if (Read || Write) begin
            state <= RELEASE;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        RELEASE: begin
          if (!Read && !Write) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
// Runs a WAIT_STATES=2 instance and a WAIT_STATES=0 instance on shared request inputs.
// Build option: MEM_RESPONDER_ERR_EN selects the out-of-range expectations.
module tb_mem_responder;

`ifdef MEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int LAT  = 3;
  localparam int LAT0 = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, rdata0;
  logic        rdy, rdy0, busy, busy0, err, err0;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [31:0] model [512];
  logic [31:0] cur_rdata = '0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(512), .WAIT_STATES(2)) dut (
    .Clock(clk), .Reset_n(rst_n), .Read(rd), .Write(wr), .Addr(addr), .Wdata(wdata),
    .Rdata(rdata), .Ready(rdy), .Busy(busy), .Err(err)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(512), .WAIT_STATES(0)) dut0 (
    .Clock(clk), .Reset_n(rst_n), .Read(rd), .Write(wr), .Addr(addr), .Wdata(wdata),
    .Rdata(rdata0), .Ready(rdy0), .Busy(busy0), .Err(err0)
  );

  // One request/response; expectations are pushed before driving and popped at Ready.
  task automatic do_op(input logic r, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input int hold);
    exp_t        e;
    int          n, n0, pulses0, extra;
    bit          seen;
    bit          oor;
    logic [31:0] r0_at;
    logic        e0_at;
    oor   = ERR_EN && (a >= 16'd512);
    e.err = oor;
    if (w) begin
      if (!oor) model[a[8:0]] = d;
      e.rdata = oor ? 32'h0 : cur_rdata;
    end else begin
      e.rdata = oor ? 32'h0 : model[a[8:0]];
    end
    cur_rdata = e.rdata;
    sb.push_back(e);

    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    n = 0; n0 = 0; pulses0 = 0; seen = 0; extra = 0;
    r0_at = '0; e0_at = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      // Request already accepted: scramble address/data to prove latching.
      if (n == 1) begin
        addr  = 16'($urandom);
        wdata = $urandom;
      end
      if (rdy0) begin
        pulses0++;
        if (n0 == 0) begin
          n0 = n; r0_at = rdata0; e0_at = err0;
        end
      end
      if (rdy) seen = 1;
      else begin
        checks++;
        if (err !== 1'b0) $display("FAIL err_idle: got %b expected 0 (addr %h)", err, a);
      end
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ready_timeout: no Ready after %0d cycles (addr %h)", n, a);
    end else begin
      if (n - 1 !== LAT) begin failures++; $display("FAIL latency: got %0d expected %0d (addr %h)", n - 1, LAT, a); end
      checks++;
      if (rdata !== e.rdata) begin failures++; $display("FAIL rdata: got %h expected %h (addr %h)", rdata, e.rdata, a); end
      checks++;
      if (err !== e.err) begin failures++; $display("FAIL err: got %b expected %b (addr %h)", err, e.err, a); end
    end
    checks++;
    if (n0 - 1 !== LAT0) begin failures++; $display("FAIL latency0: got %0d expected %0d (addr %h)", n0 - 1, LAT0, a); end
    checks++;
    if (r0_at !== e.rdata || e0_at !== e.err) begin
      failures++;
      $display("FAIL rdata0: got %h/%b expected %h/%b (addr %h)", r0_at, e0_at, e.rdata, e.err, a);
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rdy0) pulses0++;
      if (rdy) extra++;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL busy_held: got %b expected 1 (cycle %0d)", busy, i); end
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    if (rdy0) pulses0++;
    if (rdy) extra++;
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL extra_ready: got %0d expected 0", extra); end
    checks++;
    if (pulses0 !== 1) begin failures++; $display("FAIL ready0_pulses: got %0d expected 1", pulses0); end
    checks++;
    if (busy !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL busy_release: got %b/%b expected 0/0", busy, busy0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy, busy, err, rdata} !== 35'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %b%b%b %h expected 000 0", rdy, busy, err, rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy0, busy0, err0, rdata0} !== 35'h0) begin
      failures++;
      $display("FAIL reset_outputs0: got %b%b%b %h expected 000 0", rdy0, busy0, err0, rdata0);
    end
  endtask

  task automatic test_write_read();
    do_op(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 0);
    do_op(1'b1, 1'b0, 16'h0010, 32'h0, 0);
  endtask

  task automatic test_held_read();
    do_op(1'b1, 1'b0, 16'h0010, 32'h0, 10);
  endtask

  task automatic test_collision();
    do_op(1'b1, 1'b1, 16'h0020, 32'h0000CAFE, 0);
    do_op(1'b1, 1'b0, 16'h0020, 32'h0, 0);
  endtask

  task automatic test_reset_abort();
    do_op(1'b0, 1'b1, 16'h0030, 32'h00000001, 0);
    do_op(1'b1, 1'b0, 16'h0030, 32'h0, 0);
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; addr = 16'h0030; wdata = 32'h12345678;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy, busy, err, rdata} !== 35'h0) begin
      failures++;
      $display("FAIL abort_outputs: got %b%b%b %h expected 000 0", rdy, busy, err, rdata);
    end
    checks++;
    if ({rdy0, busy0, err0, rdata0} !== 35'h0) begin
      failures++;
      $display("FAIL abort_outputs0: got %b%b%b %h expected 000 0", rdy0, busy0, err0, rdata0);
    end
    @(negedge clk);
    wr = 1'b0;
    rst_n = 1'b1;
    cur_rdata = '0;
    @(negedge clk);
    do_op(1'b1, 1'b0, 16'h0030, 32'h0, 0);
  endtask

  task automatic test_out_of_range();
    do_op(1'b0, 1'b1, 16'h0000, 32'h00000077, 0);
    do_op(1'b1, 1'b0, 16'h0010, 32'h0, 0);
    do_op(1'b0, 1'b1, 16'h0200, 32'h000000A5, 0);
    do_op(1'b1, 1'b0, 16'h0000, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    int          k;
    do_op(1'b0, 1'b1, 16'h0040, 32'h40404040, 0);
    for (int i = 0; i < 10; i++) begin
      a = 16'h0010 * 16'($urandom_range(1, 4));
      k = $urandom_range(0, 2);
      do_op(k != 1, k != 0, a, $urandom, 0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held_read();
    test_collision();
    test_reset_abort();
    test_out_of_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
